riscv_lsu: RTL and testbench
============================

// Module: riscv_lsu
// PURPOSE
//  Parametrised load/store unit; successor to the single-cycle data-memory path.
//  Takes one load/store per handshake from the core datapath and drives a
//  word-addressed bus with a req/ack handshake and byte enables.
//  Adds variable-latency memory, a stall output, misalign/illegal/timeout errors
//  and RV64 LD/LWU/SD support.
// PARAMETERS
//  XLEN      32   data width; 32 or 64 (bus word = XLEN)
//  ADDR_W    32   byte-address width
//  TIMEOUT   255  max cycles waiting for bus_ack before error; >=1
// PORTS
//  cpu_clk      in   1          clock; all state on rising edge
//  reset        in   1          synchronous, active-high reset
//  req_valid_i  in   1          datapath issues a load/store
//  req_ready_o  out  1          LSU idle, can accept
//  req_we_i     in   1          1=store, 0=load
//  req_func3_i  in   3          RISC-V funct3 (size/sign)
//  req_addr_i   in   ADDR_W     byte address (ALU result)
//  req_wdata_i  in   XLEN       store data (rs2), LSB-aligned
//  rsp_valid_o  out  1          one-cycle pulse: op complete
//  rsp_rdata_o  out  XLEN       extended load data; 0 for stores/errors
//  rsp_err_o    out  1          valid with rsp_valid_o: misaligned/illegal/timeout
//  stall_o      out  1          core must hold PC/writeback
//  bus_req_o    out  1          bus request, held until ack
//  bus_we_o     out  1          bus write
//  bus_addr_o   out  ADDR_W     word-aligned address (low log2(XLEN/8) bits 0)
//  bus_be_o     out  XLEN/8     byte enables
//  bus_wdata_o  out  XLEN       store data shifted into lanes
//  bus_ack_i    in   1          bus completes transfer this cycle
//  bus_rdata_i  in   XLEN       read word, valid with bus_ack_i
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except req_ready_o=1; timeout counter 0.
//    Reset mid-transfer abandons it: bus_req_o low next cycle, no rsp pulse.
//  - FSM IDLE -> BUS -> RESP -> IDLE; IDLE -> RESP on error; TIMEOUT BUS -> RESP.
//  - req_ready_o = (state==IDLE). Accept on req_valid_i & req_ready_o; request
//    fields are registered at accept, so inputs may change afterwards.
//  - Size/legality by func3: 000 B, 001 H, 010 W, 100 BU, 101 HU (all XLEN);
//    011 D and 110 WU only when XLEN=64; otherwise illegal.
//    Stores: only 000/001/010 (+011 at XLEN=64) legal.
//  - Misaligned: address not a multiple of the access size -> error.
//  - Illegal/misaligned: no bus cycle. Next cycle RESP: rsp_valid_o=1,
//    rsp_err_o=1, rsp_rdata_o=0.
//  - Legal: bus_req_o/we/addr/be/wdata asserted from cycle after accept, held
//    stable until the cycle bus_ack_i=1. Ack may arrive in the first bus cycle.
//  - bus_be_o = size mask << addr offset. bus_wdata_o = wdata shifted left by
//    8*offset.
//  - Loads: rdata >> 8*offset, then sign- or zero-extended to XLEN per func3.
//  - Ack in cycle k -> rsp_valid_o=1 in cycle k+1 with data. Minimum latency
//    accept-to-rsp = 2 cycles (error path: 1).
//  - Timeout: counter runs in BUS. At TIMEOUT cycles without ack, drop
//    bus_req_o and go to RESP with rsp_err_o=1.
//  - bus_ack_i outside BUS is ignored.
//  - stall_o = (IDLE & req_valid_i) | BUS. It is low in RESP so the core
//    advances exactly on rsp_valid_o.
//  - A new request may be accepted in the cycle after RESP; there are no
//    back-to-back accepts from RESP.
// STRUCTURE
//  - riscv_pkg: lsu_state_e {IDLE,BUS,RESP}; funct3 constants F3_B/H/W/D/BU/HU/WU;
//    lsu_size_e.
//  - Sub-module lsu_align (combinational): size/offset -> be, wdata lane
//    shift, rdata extract + extend, misalign/illegal flags. Top holds FSM,
//    request regs, timeout counter.
// TESTING
//  1 LW addr 0x104, ack 1st bus cycle, rdata 0xDEADBEEF -> bus_be 1111;
//    rsp 2 cycles after accept, rdata 0xDEADBEEF, err 0.
//  2 LB addr 0x103, rdata 0x80xxxxxx -> be 1000, rsp 0xFFFFFF80;
//    LBU same -> 0x00000080.
//  3 SH addr 0x102, wdata 0x1234 -> be 1100, bus_wdata 0x1234_0000,
//    we 1, rsp err 0.
//  4 LW addr 0x101 -> no bus_req ever, rsp 1 cycle after accept, err 1,
//    rdata 0; func3 011 at XLEN=32 -> same.
//  5 TIMEOUT=4, never ack -> bus_req high 4 cycles, then rsp err 1;
//    stall_o high throughout, low on rsp cycle.
//  6 Reset on 2nd BUS cycle -> bus_req 0, ready 1 next cycle, no rsp pulse;
//    also ack delayed 7 cycles with XLEN=64 LD at 0x108.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the load/store unit: FSM states, access sizes, funct3 codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Access size encoded as log2(bytes); this equals funct3[1:0].
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for one access: byte enables, store-data shift, load extract/extend, legality.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: we_i/func3_i/offset_i describe the access; wdata_i is LSB-aligned store data;
//        rdata_i is the raw bus word; be_o/wdata_o are lane-steered; rdata_o is the
//        extended load value; illegal_o flags an unsupported funct3, misalign_o an
//        address not a multiple of the access size.
module lsu_align
  import riscv_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic             we_i,
  input  logic [2:0]       func3_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [NB-1:0]    be_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic [XLEN-1:0]  rdata_o,
  output logic             illegal_o,
  output logic             misalign_o
);

  localparam bit IS64 = (XLEN == 64);

  lsu_size_e       size;
  logic [3:0]      nbytes;
  logic [NB-1:0]   mask;
  logic [XLEN-1:0] rshift;

  always_comb begin
    size   = lsu_size_e'(func3_i[1:0]);
    nbytes = 4'd8;
    case (size)
      SZ_B:    nbytes = 4'd1;
      SZ_H:    nbytes = 4'd2;
      SZ_W:    nbytes = 4'd4;
      default: nbytes = 4'd8;
    endcase

    if (we_i) begin
      illegal_o = !((func3_i == F3_B) || (func3_i == F3_H) || (func3_i == F3_W) ||
                    (IS64 && (func3_i == F3_D)));
    end else begin
      case (func3_i)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal_o = 1'b0;
        F3_D, F3_WU:                    illegal_o = !IS64;
        default:                        illegal_o = 1'b1;
      endcase
    end

    // Only meaningful for legal sizes, which never exceed the bus word.
    misalign_o = |(offset_i & OFF_W'(nbytes - 4'd1));

    mask = '0;
    for (int i = 0; i < NB; i++) begin
      mask[i] = (i < int'(nbytes));
    end
    be_o    = mask << offset_i;
    wdata_o = wdata_i << {offset_i, 3'b000};

    rshift = rdata_i >> {offset_i, 3'b000};
    case (func3_i)
      F3_B:       rdata_o = XLEN'($signed(rshift[7:0]));
      F3_BU:      rdata_o = XLEN'(rshift[7:0]);
      F3_H:       rdata_o = XLEN'($signed(rshift[15:0]));
      F3_HU:      rdata_o = XLEN'(rshift[15:0]);
      F3_W:       rdata_o = XLEN'($signed(rshift[31:0]));
      F3_WU:      rdata_o = XLEN'(rshift[31:0]);
      default:    rdata_o = rshift;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one request per handshake, word-addressed req/ack bus, errors and timeout.
// Latency: accept-to-rsp 2 cycles minimum on the bus path (ack in first bus cycle), 1 on error.
// Backpressure: req_ready_o only in IDLE; bus request held until bus_ack_i or TIMEOUT.
// Ports: req_* from the datapath (valid/ready), rsp_* one-cycle completion pulse,
//        stall_o holds the core, bus_* drive the data memory, bus_ack_i/bus_rdata_i return.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                cpu_clk,
  input  logic                reset,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [2:0]          req_func3_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [XLEN-1:0]     req_wdata_i,
  output logic                rsp_valid_o,
  output logic [XLEN-1:0]     rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                stall_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [XLEN/8-1:0]   bus_be_o,
  output logic [XLEN-1:0]     bus_wdata_o,
  input  logic                bus_ack_i,
  input  logic [XLEN-1:0]     bus_rdata_i
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              is_idle, in_bus, in_resp, accept;
  logic              al_we;
  logic [2:0]        al_func3;
  logic [OFF_W-1:0]  al_off;
  logic [XLEN-1:0]   al_wdata_in;
  logic [NB-1:0]     al_be;
  logic [XLEN-1:0]   al_wdata, al_rdata;
  logic              al_illegal, al_misalign;

  assign is_idle = (state_q == IDLE);
  assign in_bus  = (state_q == BUS);
  assign in_resp = (state_q == RESP);
  assign accept  = req_valid_i && is_idle;

  // One align unit serves both phases: in IDLE it judges the incoming request,
  // afterwards it works from the registered copy so the bus stays stable.
  assign al_we       = is_idle ? req_we_i                 : we_q;
  assign al_func3    = is_idle ? req_func3_i              : func3_q;
  assign al_off      = is_idle ? req_addr_i[OFF_W-1:0]    : addr_q[OFF_W-1:0];
  assign al_wdata_in = is_idle ? req_wdata_i              : wdata_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .we_i       (al_we),
    .func3_i    (al_func3),
    .offset_i   (al_off),
    .wdata_i    (al_wdata_in),
    .rdata_i    (bus_rdata_i),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .illegal_o  (al_illegal),
    .misalign_o (al_misalign)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we_i;
          func3_d = req_func3_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rdata_d = '0;
          cnt_d   = '0;
          // Bad requests skip the bus entirely and report next cycle.
          if (al_illegal || al_misalign) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (bus_ack_i) begin
          rdata_d = we_q ? '0 : al_rdata;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      func3_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o = is_idle;
  assign stall_o     = (is_idle && req_valid_i) || in_bus;

  assign bus_req_o   = in_bus;
  assign bus_we_o    = in_bus && we_q;
  assign bus_addr_o  = in_bus ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus_be_o    = in_bus ? al_be : '0;
  assign bus_wdata_o = (in_bus && we_q) ? al_wdata : '0;

  assign rsp_valid_o = in_resp;
  assign rsp_err_o   = in_resp && err_q;
  assign rsp_rdata_o = in_resp ? rdata_q : '0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: a 32-bit instance (TIMEOUT 4) and a 64-bit instance (TIMEOUT 10),
// exercised one at a time by directed cases and random traffic against a transaction model.
module tb_riscv_lsu;

  localparam int TMO32 = 4;
  localparam int TMO64 = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Index 0 = 32-bit DUT, index 1 = 64-bit DUT.
  logic        req_valid [2];
  logic        req_we    [2];
  logic [2:0]  req_func3 [2];
  logic [31:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic        bus_ack   [2];
  logic [63:0] bus_rdata [2];

  logic        ready   [2];
  logic        rsp_valid [2];
  logic        rsp_err [2];
  logic        stall   [2];
  logic        bus_req [2];
  logic        bus_we  [2];
  logic [31:0] bus_addr [2];
  logic [63:0] rsp_rdata [2];
  logic [63:0] bus_wdata [2];
  logic [7:0]  bus_be  [2];

  logic [31:0] o32_rd, o32_wd;
  logic [3:0]  o32_be;
  logic [63:0] o64_rd, o64_wd;
  logic [7:0]  o64_be;

  assign rsp_rdata[0] = {32'b0, o32_rd};
  assign bus_wdata[0] = {32'b0, o32_wd};
  assign bus_be[0]    = {4'b0, o32_be};
  assign rsp_rdata[1] = o64_rd;
  assign bus_wdata[1] = o64_wd;
  assign bus_be[1]    = o64_be;

  riscv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TMO32)) dut32 (
    .cpu_clk(clk), .reset(reset),
    .req_valid_i(req_valid[0]), .req_ready_o(ready[0]), .req_we_i(req_we[0]),
    .req_func3_i(req_func3[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0][31:0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(o32_rd), .rsp_err_o(rsp_err[0]), .stall_o(stall[0]),
    .bus_req_o(bus_req[0]), .bus_we_o(bus_we[0]), .bus_addr_o(bus_addr[0]), .bus_be_o(o32_be),
    .bus_wdata_o(o32_wd), .bus_ack_i(bus_ack[0]), .bus_rdata_i(bus_rdata[0][31:0])
  );

  riscv_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TMO64)) dut64 (
    .cpu_clk(clk), .reset(reset),
    .req_valid_i(req_valid[1]), .req_ready_o(ready[1]), .req_we_i(req_we[1]),
    .req_func3_i(req_func3[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(o64_rd), .rsp_err_o(rsp_err[1]), .stall_o(stall[1]),
    .bus_req_o(bus_req[1]), .bus_we_o(bus_we[1]), .bus_addr_o(bus_addr[1]), .bus_be_o(o64_be),
    .bus_wdata_o(o64_wd), .bus_ack_i(bus_ack[1]), .bus_rdata_i(bus_rdata[1])
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Per-cycle expected outputs for each DUT, written by the stimulus as it walks a transaction.
  bit        exp_ready [2], exp_stall [2], exp_breq [2], exp_bwe [2];
  bit        exp_rv [2], exp_rerr [2], exp_chkwd [2];
  bit [31:0] exp_baddr [2];
  bit [7:0]  exp_bbe [2];
  bit [63:0] exp_bwd [2], exp_rd [2];

  always @(negedge clk) begin
    if (chk_on) begin
      for (int w = 0; w < 2; w++) begin
        chk($sformatf("ready[%0d]", w),     ready[w],     exp_ready[w]);
        chk($sformatf("stall[%0d]", w),     stall[w],     exp_stall[w]);
        chk($sformatf("bus_req[%0d]", w),   bus_req[w],   exp_breq[w]);
        chk($sformatf("bus_we[%0d]", w),    bus_we[w],    exp_bwe[w]);
        chk($sformatf("bus_addr[%0d]", w),  bus_addr[w],  exp_baddr[w]);
        chk($sformatf("bus_be[%0d]", w),    bus_be[w],    exp_bbe[w]);
        if (exp_chkwd[w]) chk($sformatf("bus_wdata[%0d]", w), bus_wdata[w], exp_bwd[w]);
        chk($sformatf("rsp_valid[%0d]", w), rsp_valid[w], exp_rv[w]);
        chk($sformatf("rsp_err[%0d]", w),   rsp_err[w],   exp_rerr[w]);
        chk($sformatf("rsp_rdata[%0d]", w), rsp_rdata[w], exp_rd[w]);
      end
    end
  end

  function automatic bit [63:0] rnd64(input int w);
    return (w == 1) ? {32'($urandom), 32'($urandom)} : {32'b0, 32'($urandom)};
  endfunction

  // Transaction-level model: what one request must do on a bus of 4 or 8 bytes.
  task automatic model(input int w, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [63:0] wd, input bit [63:0] rword, output bit err,
                       output bit [7:0] be, output bit [63:0] wl, output bit [63:0] rd,
                       output bit [31:0] ba);
    int nb, off, sz;
    bit legal;
    bit [63:0] xmask, sh;
    nb    = (w == 1) ? 8 : 4;
    xmask = (w == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    off   = int'(addr % nb);
    sz    = 1 << f3[1:0];
    if (we) legal = (f3 <= 3'd2) || (f3 == 3'd3 && w == 1);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || ((f3 == 3'd3 || f3 == 3'd6) && w == 1);
    err = !legal || ((addr % sz) != 0);
    be  = 8'((((1 << sz) - 1) << off) & ((1 << nb) - 1));
    wl  = (wd << (8 * off)) & xmask;
    sh  = (rword & xmask) >> (8 * off);
    case (f3)
      3'd0:    rd = {{56{sh[7]}}, sh[7:0]};
      3'd4:    rd = {56'b0, sh[7:0]};
      3'd1:    rd = {{48{sh[15]}}, sh[15:0]};
      3'd5:    rd = {48'b0, sh[15:0]};
      3'd2:    rd = {{32{sh[31]}}, sh[31:0]};
      3'd6:    rd = {32'b0, sh[31:0]};
      default: rd = sh;
    endcase
    rd = rd & xmask;
    ba = addr & ~32'(nb - 1);
  endtask

  task automatic set_idle(input int w);
    exp_ready[w] = 1'b1; exp_stall[w] = req_valid[w];
    exp_breq[w] = 1'b0; exp_bwe[w] = 1'b0; exp_baddr[w] = '0; exp_bbe[w] = '0;
    exp_chkwd[w] = 1'b1; exp_bwd[w] = '0;
    exp_rv[w] = 1'b0; exp_rerr[w] = 1'b0; exp_rd[w] = '0;
    bus_ack[w] = 1'($urandom);          // must be ignored outside the bus phase
    bus_rdata[w] = rnd64(w);
  endtask

  task automatic set_bus(input int w, input bit we, input bit [31:0] ba, input bit [7:0] be,
                         input bit [63:0] wl);
    exp_ready[w] = 1'b0; exp_stall[w] = 1'b1;
    exp_breq[w] = 1'b1; exp_bwe[w] = we; exp_baddr[w] = ba; exp_bbe[w] = be;
    exp_chkwd[w] = we; exp_bwd[w] = wl;
    exp_rv[w] = 1'b0; exp_rerr[w] = 1'b0; exp_rd[w] = '0;
  endtask

  task automatic set_rsp(input int w, input bit err, input bit [63:0] rd);
    exp_ready[w] = 1'b0; exp_stall[w] = 1'b0;
    exp_breq[w] = 1'b0; exp_bwe[w] = 1'b0; exp_baddr[w] = '0; exp_bbe[w] = '0;
    exp_chkwd[w] = 1'b1; exp_bwd[w] = '0;
    exp_rv[w] = 1'b1; exp_rerr[w] = err; exp_rd[w] = rd;
    bus_ack[w] = 1'($urandom);
    bus_rdata[w] = rnd64(w);
  endtask

  // Observations from the last transaction, for the literal checks.
  bit [63:0] obs_be, obs_wdata, obs_rdata;
  bit        obs_err;
  int        obs_lat, obs_nreq, obs_rsp;

  // dly: ack arrives in bus cycle dly+1 (negative = never). rst_at: assert reset in that bus cycle.
  task automatic run_op(input int w, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [63:0] wd, input int dly, input bit [63:0] rword_in,
                        input int rst_at);
    bit err, timed_out;
    bit [7:0] be;
    bit [63:0] wl, rd, rword;
    bit [31:0] ba;
    int tmo, ack_cyc, lat;
    rword = (w == 1) ? rword_in : {32'b0, rword_in[31:0]};
    model(w, we, f3, addr, wd, rword, err, be, wl, rd, ba);
    tmo     = (w == 1) ? TMO64 : TMO32;
    ack_cyc = (dly < 0) ? 0 : dly + 1;
    obs_be = '0; obs_wdata = '0; obs_rdata = '0; obs_err = 1'b0;
    obs_lat = 0; obs_nreq = 0; obs_rsp = 0;

    req_valid[w] = 1'b1; req_we[w] = we; req_func3[w] = f3; req_addr[w] = addr;
    req_wdata[w] = (w == 1) ? wd : {32'b0, wd[31:0]};
    set_idle(w);
    @(posedge clk); #1;
    // Request is registered at accept; scramble the inputs to prove it.
    req_valid[w] = 1'b0; req_we[w] = 1'($urandom); req_func3[w] = 3'($urandom);
    req_addr[w] = 32'($urandom); req_wdata[w] = rnd64(w);
    lat = 1;

    if (err) begin
      set_rsp(w, 1'b1, 64'b0);
      obs_rsp += int'(rsp_valid[w]); obs_rdata = rsp_rdata[w]; obs_err = rsp_err[w];
      obs_lat = lat; obs_nreq += int'(bus_req[w]);
      @(posedge clk); #1;
      set_idle(w);
      return;
    end

    timed_out = 1'b1;
    for (int i = 1; i <= tmo; i++) begin
      set_bus(w, we, ba, be, wl);
      bus_ack[w]   = (i == ack_cyc);
      bus_rdata[w] = (i == ack_cyc) ? rword : rnd64(w);
      if (i == rst_at) reset = 1'b1;
      obs_be = bus_be[w]; obs_wdata = bus_wdata[w]; obs_nreq += int'(bus_req[w]);
      @(posedge clk); #1;
      lat++;
      if (i == rst_at) begin
        reset = 1'b0;
        set_idle(w);
        obs_rsp += int'(rsp_valid[w]);
        return;
      end
      if (i == ack_cyc) begin
        timed_out = 1'b0;
        break;
      end
    end

    set_rsp(w, timed_out, (timed_out || we) ? 64'b0 : rd);
    obs_rsp += int'(rsp_valid[w]); obs_rdata = rsp_rdata[w]; obs_err = rsp_err[w];
    obs_lat = lat;
    @(posedge clk); #1;
    set_idle(w);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    int        w, dly, sz;

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_func3[k] = '0;
      req_addr[k] = '0; req_wdata[k] = '0;
      set_idle(k);
    end
    @(posedge clk); #1;
    chk_on = 1'b1;             // reset state is checked from here on
    @(posedge clk); #1;
    reset = 1'b0;

    // LW aligned, ack in first bus cycle.
    run_op(0, 1'b0, 3'b010, 32'h104, 64'h0, 0, 64'hDEAD_BEEF, -1);
    chk("t1_be", obs_be, 64'hF);
    chk("t1_lat", obs_lat, 2);
    chk("t1_rdata", obs_rdata, 64'hDEAD_BEEF);
    chk("t1_err", obs_err, 0);

    // LB / LBU from the top byte lane.
    run_op(0, 1'b0, 3'b000, 32'h103, 64'h0, 1, 64'h8012_3456, -1);
    chk("t2_be", obs_be, 64'h8);
    chk("t2_lb", obs_rdata, 64'hFFFF_FF80);
    run_op(0, 1'b0, 3'b100, 32'h103, 64'h0, 0, 64'h8012_3456, -1);
    chk("t2_lbu", obs_rdata, 64'h80);

    // SH into the upper half-word.
    run_op(0, 1'b1, 3'b001, 32'h102, 64'h1234, 2, 64'h0, -1);
    chk("t3_be", obs_be, 64'hC);
    chk("t3_wdata", obs_wdata, 64'h1234_0000);
    chk("t3_err", obs_err, 0);
    chk("t3_rdata", obs_rdata, 0);

    // Misaligned LW and D on a 32-bit bus: no bus cycle, error after one cycle.
    run_op(0, 1'b0, 3'b010, 32'h101, 64'h0, 0, 64'h1, -1);
    chk("t4_nreq", obs_nreq, 0);
    chk("t4_lat", obs_lat, 1);
    chk("t4_err", obs_err, 1);
    chk("t4_rdata", obs_rdata, 0);
    run_op(0, 1'b0, 3'b011, 32'h100, 64'h0, 0, 64'h1, -1);
    chk("t4d_nreq", obs_nreq, 0);
    chk("t4d_err", obs_err, 1);

    // Never acked: four bus cycles then error.
    run_op(0, 1'b0, 3'b010, 32'h100, 64'h0, -1, 64'h0, -1);
    chk("t5_nreq", obs_nreq, 4);
    chk("t5_lat", obs_lat, 5);
    chk("t5_err", obs_err, 1);

    // Reset in the second bus cycle abandons the transfer.
    run_op(1, 1'b0, 3'b011, 32'h108, 64'h0, 5, 64'h1, 2);
    chk("t6_rst_nreq", obs_nreq, 2);
    chk("t6_rst_rsp", obs_rsp, 0);

    // LD with ack seven cycles late.
    run_op(1, 1'b0, 3'b011, 32'h108, 64'h0, 7, 64'h8877_6655_4433_2211, -1);
    chk("t6_be", obs_be, 64'hFF);
    chk("t6_lat", obs_lat, 9);
    chk("t6_rdata", obs_rdata, 64'h8877_6655_4433_2211);
    chk("t6_err", obs_err, 0);

    // LW vs LWU on the upper word of a 64-bit bus.
    run_op(1, 1'b0, 3'b010, 32'h10C, 64'h0, 0, 64'hF123_4567_0000_0000, -1);
    chk("t7_lw", obs_rdata, 64'hFFFF_FFFF_F123_4567);
    run_op(1, 1'b0, 3'b110, 32'h10C, 64'h0, 0, 64'hF123_4567_0000_0000, -1);
    chk("t7_lwu", obs_rdata, 64'h0000_0000_F123_4567);

    // Random traffic on both widths.
    for (int n = 0; n < 300; n++) begin
      w    = $urandom_range(0, 1);
      we   = 1'($urandom);
      f3   = 3'($urandom);
      sz   = 1 << f3[1:0];
      addr = 32'($urandom);
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(sz - 1);
      dly  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
      run_op(w, we, f3, addr, rnd64(w), dly, rnd64(w), -1);
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
